// File: rtl/bitbal_pkg.sv
// Shared types and helpers for the bit-balance scheduler.
// Optional balanced flag is enabled by defining BITBAL_FLAG_EN.
package bitbal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = $clog2(DATA_W_DEF + 1);

  function automatic int next_ptr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

  // Words up to 64 bits are zero-extended by the caller.
  function automatic int popcount(input logic [63:0] w);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + (w[i] ? 1 : 0);
    end
    return c;
  endfunction

endpackage

// File: rtl/bitbal_core.sv
// Registered popcount core: count follows the set-bit total of a with one cycle of latency.
module bitbal_core
  import bitbal_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  output logic [CNT_W-1:0]  count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= CNT_W'(popcount(64'(a)));
    end
  end

endmodule

// File: rtl/bitbalancer_sched.sv
// Round-robin scheduler sharing one popcount core among NREQ requesters.
// Define BITBAL_FLAG_EN to build the registered balanced flag on rsp_bal.
module bitbalancer_sched
  import bitbal_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1),
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CNT_W-1:0]       rsp_count,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_bal,
  output logic                   busy
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] data_q;
  logic              found;
  logic              accept;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grants are suppressed while reset is asserted so nothing looks accepted.
  assign accept    = found && (state == IDLE) && reset;
  assign req_ready = accept ? (NREQ'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= req_data[win*DATA_W +: DATA_W];
            id_q   <= win;
            rr_ptr <= ID_W'(next_ptr(int'(win), NREQ));
            state  <= EXEC;
          end
        end
        EXEC:    state <= RESP;
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bitbal_core #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .a    (data_q),
    .count(rsp_count)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

`ifdef BITBAL_FLAG_EN
  logic bal_q;

  // Tracks the core register on the same edges, so flag and count stay aligned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bal_q <= 1'b0;
    end else begin
      bal_q <= (popcount(64'(data_q)) == DATA_W / 2);
    end
  end

  assign rsp_bal = bal_q;
`else
  assign rsp_bal = 1'b0;
`endif

endmodule

// File: tb/tb_bitbalancer_sched.sv
// Directed self-checking bench for bitbalancer_sched (NREQ=4, DATA_W=8).
module tb_bitbalancer_sched;

`ifdef BITBAL_FLAG_EN
  localparam logic BAL = 1'b1;
`else
  localparam logic BAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_count;
  logic [1:0]  rsp_id;
  logic        rsp_bal;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pre_reset;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [3:0]  exp_cnt;
    logic        exp_bal;
  } vec_t;

  vec_t vecs[9];

  bitbalancer_sched #(
    .NREQ  (4),
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_count(rsp_count),
    .rsp_id   (rsp_id),
    .rsp_bal  (rsp_bal),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One full transaction with rsp_ready held high: grant, EXEC, RESP.
  task automatic runVector(input vec_t t, input int n);
    if (t.pre_reset) pulseReset();
    applyStimulus(t.valid, t.data);
    checkOutput($sformatf("v%0d ready", n), req_ready, t.exp_ready);
    @(negedge clk);
    req_valid = '0;
    checkOutput($sformatf("v%0d exec busy", n), busy, 1);
    checkOutput($sformatf("v%0d exec rsp_valid", n), rsp_valid, 0);
    checkOutput($sformatf("v%0d exec ready", n), req_ready, 0);
    @(negedge clk);
    checkOutput($sformatf("v%0d rsp_valid", n), rsp_valid, 1);
    checkOutput($sformatf("v%0d rsp_count", n), rsp_count, t.exp_cnt);
    checkOutput($sformatf("v%0d rsp_id", n), rsp_id, t.exp_id);
    checkOutput($sformatf("v%0d rsp_bal", n), rsp_bal, t.exp_bal);
  endtask

  initial begin
    vecs[0] = '{pre_reset: 1'b0, valid: 4'b0001, data: 32'h000000AB, exp_ready: 4'b0001, exp_id: 2'd0, exp_cnt: 4'd5, exp_bal: 1'b0};
    vecs[1] = '{pre_reset: 1'b1, valid: 4'b1111, data: 32'h01FF00F0, exp_ready: 4'b0001, exp_id: 2'd0, exp_cnt: 4'd4, exp_bal: BAL};
    vecs[2] = '{pre_reset: 1'b0, valid: 4'b1110, data: 32'h01FF00F0, exp_ready: 4'b0010, exp_id: 2'd1, exp_cnt: 4'd0, exp_bal: 1'b0};
    vecs[3] = '{pre_reset: 1'b0, valid: 4'b1100, data: 32'h01FF00F0, exp_ready: 4'b0100, exp_id: 2'd2, exp_cnt: 4'd8, exp_bal: 1'b0};
    vecs[4] = '{pre_reset: 1'b0, valid: 4'b1000, data: 32'h01FF00F0, exp_ready: 4'b1000, exp_id: 2'd3, exp_cnt: 4'd1, exp_bal: 1'b0};
    vecs[5] = '{pre_reset: 1'b0, valid: 4'b1111, data: 32'h0F0F3C55, exp_ready: 4'b0001, exp_id: 2'd0, exp_cnt: 4'd4, exp_bal: BAL};
    vecs[6] = '{pre_reset: 1'b0, valid: 4'b1001, data: 32'h070000FF, exp_ready: 4'b1000, exp_id: 2'd3, exp_cnt: 4'd3, exp_bal: 1'b0};
    vecs[7] = '{pre_reset: 1'b0, valid: 4'b0110, data: 32'h007E8000, exp_ready: 4'b0010, exp_id: 2'd1, exp_cnt: 4'd1, exp_bal: 1'b0};
    vecs[8] = '{pre_reset: 1'b0, valid: 4'b0011, data: 32'h00000F00, exp_ready: 4'b0001, exp_id: 2'd0, exp_cnt: 4'd0, exp_bal: 1'b0};

    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset held with every requester asserting valid.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset req_ready", req_ready, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rsp_count", rsp_count, 0);
    checkOutput("reset rsp_id", rsp_id, 0);
    checkOutput("reset rsp_bal", rsp_bal, 0);
    req_valid = '0;
    reset     = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runVector(vecs[i], i);
    end

    // Backpressure: pointer is at 1, requester 2 served, then held in RESP.
    applyStimulus(4'b0100, 32'h00C30000);
    checkOutput("bp ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp rsp_valid", rsp_valid, 1);
    checkOutput("bp rsp_count", rsp_count, 4);
    checkOutput("bp rsp_id", rsp_id, 2);
    checkOutput("bp rsp_bal", rsp_bal, BAL);
    req_valid = 4'b1111;
    req_data  = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d rsp_valid", c), rsp_valid, 1);
      checkOutput($sformatf("bp hold%0d rsp_count", c), rsp_count, 4);
      checkOutput($sformatf("bp hold%0d rsp_id", c), rsp_id, 2);
      checkOutput($sformatf("bp hold%0d rsp_bal", c), rsp_bal, BAL);
      checkOutput($sformatf("bp hold%0d req_ready", c), req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp release busy", busy, 0);
    checkOutput("bp next grant", req_ready, 4'b1000);
    req_valid = '0;

    // Reset during EXEC discards the word and returns the pointer to 0.
    applyStimulus(4'b0010, 32'h0000FF00);
    checkOutput("mid ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    checkOutput("mid exec busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid rst rsp_valid", rsp_valid, 0);
    checkOutput("mid rst busy", busy, 0);
    checkOutput("mid rst rsp_count", rsp_count, 0);
    checkOutput("mid rst rsp_id", rsp_id, 0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("mid quiet%0d rsp_valid", c), rsp_valid, 0);
      checkOutput($sformatf("mid quiet%0d busy", c), busy, 0);
    end
    runVector('{pre_reset: 1'b0, valid: 4'b1111, data: 32'hAAAAAA3C,
                exp_ready: 4'b0001, exp_id: 2'd0, exp_cnt: 4'd4, exp_bal: BAL}, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
